// File: rtl/mio_bus.sv
// mio_bus: CPU memory/IO bridge that decodes requests to a wait-stated data RAM, GPIO and an
// optional free-running cycle counter enabled by defining MIO_COUNTER_EN.
module mio_bus #(
  parameter int RAM_AW   = 10,
  parameter int RAM_WAIT = 2,
  parameter int LED_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              CPU_MIO,
  input  logic [31:0]       addr_bus,
  input  logic [31:0]       Cpu_data2bus,
  output logic [31:0]       Cpu_data4bus,
  output logic              MIO_ready,
  output logic              bus_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic [LED_W-1:0]  sw_in,
  output logic [LED_W-1:0]  led_out
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic [RAM_AW-1:0] addr_q;
  logic [31:0] wdata_q, cnt_rd;
  logic [3:0] wcnt;
  logic [LED_W-1:0] sw_meta, sw_sync;
  logic wr_q, req, start, last, hit_ram, hit_gpio, hit_cnt, hit_none;
  logic unused_addr;
  assign unused_addr = ^{addr_bus[27:RAM_AW+2], addr_bus[1:0]};
`ifdef MIO_COUNTER_EN
  logic [31:0] counter;
  assign hit_cnt = addr_bus[31:28] == 4'hF && addr_bus[2];
  assign cnt_rd = counter;
  // a counter write replaces that cycle's increment
  always_ff @(posedge clk or negedge reset)
    if (!reset) counter <= '0;
    else counter <= (start && MemWrite && hit_cnt) ? Cpu_data2bus : counter + 32'd1;
`else
  assign hit_cnt = 1'b0;
  assign cnt_rd = '0;
`endif
  always_comb begin
    req = (MemRead | MemWrite) & CPU_MIO;
    start = state == IDLE && req;
    last = state == ACCESS && wcnt == 4'd0;
    hit_ram = addr_bus[31:28] == 4'h0;
    hit_gpio = addr_bus[31:28] == 4'hE;
    hit_none = !(hit_ram || hit_gpio || hit_cnt);
    state_nx = state == IDLE ? (req ? (hit_ram ? ACCESS : RESP) : IDLE)
             : state == ACCESS ? (last ? RESP : ACCESS) : IDLE;
    ram_en = state == ACCESS;
    ram_we = last && wr_q;
    ram_addr = addr_q;
    ram_din = wdata_q;
    MIO_ready = state == RESP;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      wr_q <= 1'b0;
      wcnt <= '0;
      Cpu_data4bus <= '0;
      bus_err <= 1'b0;
      led_out <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      state <= state_nx;
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
      if (start) begin
        addr_q <= addr_bus[RAM_AW+1:2];
        wdata_q <= Cpu_data2bus;
        wr_q <= MemWrite;
        wcnt <= 4'(RAM_WAIT - 1);
        if ((MemRead && MemWrite) || hit_none) bus_err <= 1'b1;
        if (MemWrite && hit_gpio) led_out <= Cpu_data2bus[LED_W-1:0];
        // peripheral and unmapped reads resolve at the request edge; RAM reads wait for ram_dout
        if (!MemWrite && !hit_ram)
          Cpu_data4bus <= hit_gpio ? 32'({led_out, sw_sync}) : hit_cnt ? cnt_rd : 32'd0;
      end else if (state == ACCESS) wcnt <= wcnt - 4'd1;
      if (last && !wr_q) Cpu_data4bus <= ram_dout;
    end
  end
endmodule

// File: tb/tb_mio_bus.sv
// tb_mio_bus: table vectors, hand sequences and random transactions against a transaction-level model.
module tb_mio_bus;
  localparam int RAM_WAIT = 2;
  localparam int RAM_AW = 10;
  localparam int LED_W = 8;
`ifdef MIO_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, CPU_MIO = 1'b0;
  logic [31:0] addr_bus = '0, Cpu_data2bus = '0, Cpu_data4bus, ram_din, ram_dout;
  logic MIO_ready, bus_err, ram_en, ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [LED_W-1:0] sw_in = '0, led_out;
  logic [31:0] ram [0:1023];
  int n_cmp = 0, n_bad = 0;
  int unsigned cyc = 0;
  logic [31:0] mem_m [0:1023];
  logic [7:0] led_m = '0, sw_m = '0;
  logic err_m = 1'b0;
  logic [31:0] rd_m = '0, cnt_v = '0;
  int unsigned cnt_l = 0;

  mio_bus #(.RAM_AW(RAM_AW), .RAM_WAIT(RAM_WAIT), .LED_W(LED_W)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .CPU_MIO(CPU_MIO),
    .addr_bus(addr_bus), .Cpu_data2bus(Cpu_data2bus), .Cpu_data4bus(Cpu_data4bus),
    .MIO_ready(MIO_ready), .bus_err(bus_err), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout), .sw_in(sw_in), .led_out(led_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (ram_en) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rdata"}, Cpu_data4bus, 0);
    chk({tag, "_ready"}, MIO_ready, 0);
    chk({tag, "_err"}, bus_err, 0);
    chk({tag, "_ram_en"}, ram_en, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_din"}, ram_din, 0);
    chk({tag, "_led"}, led_out, 0);
  endtask

  task automatic set_sw(input logic [7:0] v);
    @(posedge clk); #1;
    sw_in = v;
    sw_m = v;
    repeat (3) @(posedge clk);
  endtask

  // one CPU transaction; returns read data, edges to MIO_ready and any ram_we pulses seen
  task automatic txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] data, output int lat, output int nwe,
                     output logic [9:0] wea, output int unsigned k);
    @(posedge clk); #1;
    MemRead = r; MemWrite = w; CPU_MIO = 1'b1; addr_bus = a; Cpu_data2bus = d;
    lat = 0; nwe = 0; wea = '0; k = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) k = cyc;
      if (ram_we) begin nwe++; wea = ram_addr; end
      if (MIO_ready) break;
    end
    MemRead = 1'b0; MemWrite = 1'b0; CPU_MIO = 1'b0;
    data = Cpu_data4bus;
    @(posedge clk); #1;
    chk("ready_one_cycle", MIO_ready, 0);
    if (ram_we) nwe++;
  endtask

  // transaction-level reference: address map, write-wins, sticky error, counter arithmetic
  task automatic ref_step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input int unsigned k, output logic [31:0] ed, output int el,
                          output int enw, output logic [9:0] ewa);
    bit ram_t, gpio_t, cnt_t, none_t;
    ram_t = a[31:28] == 4'h0;
    gpio_t = a[31:28] == 4'hE;
    cnt_t = CNT_EN && a[31:28] == 4'hF && a[2];
    none_t = !(ram_t || gpio_t || cnt_t);
    if ((r && w) || none_t) err_m = 1'b1;
    el = ram_t ? RAM_WAIT + 1 : 1;
    enw = (ram_t && w) ? 1 : 0;
    ewa = (ram_t && w) ? a[11:2] : 10'd0;
    if (w) begin
      if (ram_t) mem_m[a[11:2]] = d;
      if (gpio_t) led_m = d[7:0];
      if (cnt_t) begin cnt_v = d; cnt_l = k; end
    end else
      rd_m = ram_t ? mem_m[a[11:2]] : gpio_t ? {16'h0, led_m, sw_m} : cnt_t ? cnt_v + (k - cnt_l - 1) : 32'h0;
    ed = rd_m;
  endtask

  task automatic check_all(input string tag, input logic [31:0] data, input int lat, input int nwe,
                           input logic [9:0] wea, input logic [31:0] ed, input int el, input int enw,
                           input logic [9:0] ewa, input logic ee, input logic [7:0] eled);
    chk({tag, "_rdata"}, data, ed);
    chk({tag, "_latency"}, lat, el);
    chk({tag, "_we_count"}, nwe, enw);
    chk({tag, "_we_addr"}, wea, ewa);
    chk({tag, "_bus_err"}, bus_err, ee);
    chk({tag, "_led"}, led_out, eled);
  endtask

  typedef struct {
    logic r, w;
    logic [31:0] a, d, exp_d;
    int exp_lat;
    logic exp_err;
    logic [7:0] exp_led;
    int exp_nwe;
    logic [9:0] exp_wea;
  } vec_t;
  vec_t tbl [8];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] data, ed, lo, a, d;
    int lat, nwe, el, enw, sel, opv;
    logic [9:0] wea, ewa;
    int unsigned k;
    logic r, w;
    logic [3:0] wi, top;
    tbl[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0, RAM_WAIT + 1, 1'b0, 8'h00, 1, 10'd4};
    tbl[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, RAM_WAIT + 1, 1'b0, 8'h00, 0, 10'd0};
    tbl[2] = '{1'b0, 1'b1, 32'hE000_0000, 32'h0000_00A5, 32'h1234_5678, 1, 1'b0, 8'hA5, 0, 10'd0};
    tbl[3] = '{1'b1, 1'b0, 32'hE000_0000, 32'h0, 32'h0000_A53C, 1, 1'b0, 8'hA5, 0, 10'd0};
    tbl[4] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1, 1'b1, 8'hA5, 0, 10'd0};
    tbl[5] = '{1'b1, 1'b1, 32'h0000_0008, 32'hCAFE_F00D, 32'h0, RAM_WAIT + 1, 1'b1, 8'hA5, 1, 10'd2};
    tbl[6] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, RAM_WAIT + 1, 1'b1, 8'hA5, 0, 10'd0};
    tbl[7] = '{1'b1, 1'b0, 32'hF000_0000, 32'h0, 32'h0, 1, 1'b1, 8'hA5, 0, 10'd0};

    repeat (3) @(posedge clk);
    #1 chk_reset("por");
    reset = 1'b1;
    cnt_v = '0; cnt_l = cyc;
    set_sw(8'h3C);

    foreach (tbl[i]) begin
      txn(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, data, lat, nwe, wea, k);
      ref_step(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, k, ed, el, enw, ewa);
      check_all($sformatf("vec%0d", i), data, lat, nwe, wea, tbl[i].exp_d, tbl[i].exp_lat,
                tbl[i].exp_nwe, tbl[i].exp_wea, tbl[i].exp_err, tbl[i].exp_led);
    end

    txn(1'b0, 1'b1, 32'hF000_0004, 32'hFFFF_FFFE, data, lat, nwe, wea, k);
    ref_step(1'b0, 1'b1, 32'hF000_0004, 32'hFFFF_FFFE, k, ed, el, enw, ewa);
    check_all("cnt_wr", data, lat, nwe, wea, ed, el, enw, ewa, err_m, led_m);
    txn(1'b1, 1'b0, 32'hF000_0004, 32'h0, data, lat, nwe, wea, k);
    ref_step(1'b1, 1'b0, 32'hF000_0004, 32'h0, k, ed, el, enw, ewa);
    check_all("cnt_rd", data, lat, nwe, wea, ed, el, enw, ewa, err_m, led_m);
`ifdef MIO_COUNTER_EN
    chk("cnt_wrapped", data, 32'h0);
`else
    chk("cnt_unmapped_err", bus_err, 1'b1);
`endif

    @(posedge clk); #1;
    MemRead = 1'b1; CPU_MIO = 1'b0; addr_bus = 32'h0000_0010;
    repeat (4) begin
      @(posedge clk); #1;
      chk("no_mio_ignored", {MIO_ready, ram_en}, 0);
    end
    MemRead = 1'b0;

    @(posedge clk); #1;
    MemWrite = 1'b1; CPU_MIO = 1'b1; addr_bus = 32'h0000_0010; Cpu_data2bus = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("abort_in_access", ram_en, 1'b1);
    chk("abort_no_we_yet", ram_we, 1'b0);
    #2 reset = 1'b0;
    #1 chk_reset("abort");
    MemWrite = 1'b0; CPU_MIO = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_we_low", ram_we, 1'b0);
    end
    reset = 1'b1;
    err_m = 1'b0; led_m = '0; rd_m = '0; cnt_v = '0; cnt_l = cyc;
    txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, data, lat, nwe, wea, k);
    ref_step(1'b1, 1'b0, 32'h0000_0010, 32'h0, k, ed, el, enw, ewa);
    check_all("abort_lost", data, lat, nwe, wea, ed, el, enw, ewa, err_m, led_m);

    for (int i = 0; i < 16; i++) begin
      lo = $urandom; d = $urandom; wi = 4'(i);
      a = {4'h0, lo[27:12], 6'h0, wi, lo[1:0]};
      txn(1'b0, 1'b1, a, d, data, lat, nwe, wea, k);
      ref_step(1'b0, 1'b1, a, d, k, ed, el, enw, ewa);
      check_all("preload", data, lat, nwe, wea, ed, el, enw, ewa, err_m, led_m);
    end

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) set_sw(8'($urandom));
      lo = $urandom; d = $urandom;
      sel = $urandom_range(0, 5);
      opv = $urandom_range(0, 7);
      r = opv == 0 || opv >= 4;
      w = opv <= 3;
      wi = 4'($urandom_range(0, 15));
      top = 4'($urandom_range(1, 13));
      a = sel <= 1 ? {4'h0, lo[27:12], 6'h0, wi, lo[1:0]}
        : sel == 2 ? {4'hE, lo[27:0]}
        : sel == 3 ? {4'hF, lo[27:3], 1'b1, lo[1:0]}
        : sel == 4 ? {4'hF, lo[27:3], 1'b0, lo[1:0]}
        : {top, lo[27:0]};
      txn(r, w, a, d, data, lat, nwe, wea, k);
      ref_step(r, w, a, d, k, ed, el, enw, ewa);
      check_all($sformatf("rnd%0d", i), data, lat, nwe, wea, ed, el, enw, ewa, err_m, led_m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
